// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the CPU memory-bus arbiter slice.
package mips_bus_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Counts consecutive slave-stall cycles of one transfer and flags when the limit is reached.
module mips_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] stall_cnt_q;
  logic [7:0] stall_cnt_d;

  // A zero limit never lets the counter move, which keeps the watchdog disabled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clear) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q < LIMIT)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign timeout = (LIMIT != 8'd0) && (stall_cnt_q == LIMIT);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-way round-robin arbiter sharing one Avalon-style bus between fetch (I) and load/store (D),
// with grant held across slave stalls and a watchdog that aborts hung transfers.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned        TIMEOUT_CYCLES = 255,
  parameter logic [WORD_W-1:0]  ERR_DATA       = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [WORD_W-1:0] i_writedata,
  input  logic [BE_W-1:0]   i_byteenable,
  output logic [WORD_W-1:0] i_readdata,
  output logic              i_waitrequest,
  input  logic [WORD_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [WORD_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic [WORD_W-1:0] d_readdata,
  output logic              d_waitrequest,
  output logic [WORD_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [WORD_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic [WORD_W-1:0] readdata,
  input  logic              waitrequest,
  output logic [1:0]        grant,
  output logic              bus_error
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;

  logic i_req;
  logic d_req;
  logic busy;
  logic timeout;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;
  assign busy  = (state_q != IDLE);

  mips_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!busy),
    .stall  (busy && waitrequest && !timeout),
    .timeout(timeout)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || (last_grant_q == GNT_D))) begin
          state_d      = BUSY_I;
          last_grant_d = GNT_I;
        end else if (d_req) begin
          state_d      = BUSY_D;
          last_grant_d = GNT_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (timeout || !waitrequest) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus side follows the owner combinationally; an abort cycle kills the strobes and fakes completion.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    grant         = 2'b00;
    i_readdata    = '0;
    i_waitrequest = 1'b1;
    d_readdata    = '0;
    d_waitrequest = 1'b1;
    bus_error     = 1'b0;
    case (state_q)
      BUSY_I: begin
        address       = i_address;
        read          = i_read & ~timeout;
        write         = i_write & ~timeout;
        writedata     = i_writedata;
        byteenable    = i_byteenable;
        grant         = 2'b01;
        i_readdata    = timeout ? ERR_DATA : readdata;
        i_waitrequest = waitrequest & ~timeout;
        bus_error     = timeout;
      end
      BUSY_D: begin
        address       = d_address;
        read          = d_read & ~timeout;
        write         = d_write & ~timeout;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        grant         = 2'b10;
        d_readdata    = timeout ? ERR_DATA : readdata;
        d_waitrequest = waitrequest & ~timeout;
        bus_error     = timeout;
      end
      default: ;
    endcase
  end

endmodule
